// File: rtl/exram_portb_arbiter.sv
// EXRAM port B arbiter: round-robin sharing between the display scanner (0)
// and the debug/loader (1), with bounded hold and I/O-window write blocking.
module exram_portb_arbiter #(
    parameter int unsigned       WIDTH    = 16,
    parameter int unsigned       ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] IO_BASE  = ADDR_W'(16'hCFFD),
    parameter int unsigned       MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [WIDTH-1:0]  wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [WIDTH-1:0]  wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [WIDTH-1:0]  rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    output logic              mem_we,
    input  logic [WIDTH-1:0]  mem_q,
    output logic              io_block
);

    localparam int unsigned       HOLD_W    = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    // One-hot owner encoding so each grant is a flop output.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    state_t            state;
    logic              rr_ptr;
    logic [HOLD_W-1:0] hold_cnt;

    logic              owner_req;
    logic              owner_we;
    logic [ADDR_W-1:0] owner_addr;
    logic [WIDTH-1:0]  owner_wdata;
    logic              other_req;
    logic              io_hit;
    logic              hold_last;
    logic              switch_owner;

    // Select the current owner's request; IDLE drives an all-zero access.
    always_comb begin
        owner_req   = 1'b0;
        owner_we    = 1'b0;
        owner_addr  = '0;
        owner_wdata = '0;
        other_req   = 1'b0;
        case (state)
            OWN0: begin
                owner_req   = req0;
                owner_we    = we0;
                owner_addr  = addr0;
                owner_wdata = wdata0;
                other_req   = req1;
            end
            OWN1: begin
                owner_req   = req1;
                owner_we    = we1;
                owner_addr  = addr1;
                owner_wdata = wdata1;
                other_req   = req0;
            end
            default: ;
        endcase
    end

    assign io_hit       = (owner_addr >= IO_BASE);
    assign hold_last    = (hold_cnt == HOLD_LAST);
    assign switch_owner = other_req & (~owner_req | hold_last);

    assign gnt0      = state[0];
    assign gnt1      = state[1];
    assign mem_addr  = owner_addr;
    assign mem_wdata = owner_wdata;
    assign mem_we    = owner_req & owner_we & ~io_hit;
    assign rdata     = mem_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            rr_ptr   <= 1'b0;
            hold_cnt <= '0;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
            io_block <= 1'b0;
        end else begin
            rvalid0  <= gnt0 & req0 & ~we0;
            rvalid1  <= gnt1 & req1 & ~we1;
            io_block <= owner_req & owner_we & io_hit;
            case (state)
                IDLE: begin
                    hold_cnt <= '0;
                    if (req0 && (!req1 || !rr_ptr)) begin
                        state <= OWN0;
                    end else if (req1) begin
                        state <= OWN1;
                    end
                end
                OWN0, OWN1: begin
                    if (switch_owner) begin
                        state    <= (state == OWN0) ? OWN1 : OWN0;
                        rr_ptr   <= (state == OWN0);
                        hold_cnt <= '0;
                    end else if (owner_req) begin
                        // Hold only accumulates while the other side is waiting.
                        if (!other_req) begin
                            hold_cnt <= '0;
                        end else if (!hold_last) begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
                    end else begin
                        state    <= IDLE;
                        hold_cnt <= '0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exram_portb_arbiter.sv
// Bench for exram_portb_arbiter: directed vector table, hand sequences for
// reset/handover corners, and random traffic against an ownership model.
module tb_exram_portb_arbiter;

    localparam int unsigned W        = 16;
    localparam int unsigned AW       = 16;
    localparam int unsigned MAX_HOLD = 4;
    localparam logic [15:0] IO_BASE  = 16'hCFFD;
    localparam int          NV       = 24;
    localparam int          NRAND    = 2000;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [W-1:0]  wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [W-1:0]  rdata;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_wdata;
    logic          mem_we;
    logic [W-1:0]  mem_q;
    logic          io_block;

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] ram     [0:65535];
    logic [15:0] ref_ram [0:65535];

    exram_portb_arbiter #(
        .WIDTH(W), .ADDR_W(AW), .IO_BASE(IO_BASE), .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1),
        .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_q(mem_q), .io_block(io_block)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM standing in for EXRAM port B.
    always @(posedge clk) begin
        mem_q <= ram[mem_addr];
        if (mem_we) ram[mem_addr] = mem_wdata;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct packed {
        logic        r0, w0;
        logic [15:0] a0;
        logic        r1, w1;
        logic [15:0] a1, d1;
        logic        g0, g1, we, v0, v1, io;
        logic [15:0] maddr, rd;
    } vec_t;

    // ctl = {req0, we0, req1, we1}; ex = {gnt0, gnt1, mem_we, rvalid0, rvalid1, io_block}
    function automatic vec_t mk(input logic [3:0] ctl, input logic [15:0] a0,
                                input logic [15:0] a1, input logic [15:0] d1,
                                input logic [5:0] ex, input logic [15:0] maddr,
                                input logic [15:0] rd);
        vec_t v;
        v.r0 = ctl[3]; v.w0 = ctl[2]; v.r1 = ctl[1]; v.w1 = ctl[0];
        v.a0 = a0; v.a1 = a1; v.d1 = d1;
        v.g0 = ex[5]; v.g1 = ex[4]; v.we = ex[3]; v.v0 = ex[2]; v.v1 = ex[1]; v.io = ex[0];
        v.maddr = maddr; v.rd = rd;
        return v;
    endfunction

    vec_t tbl [NV];

    // Random-phase model state
    int          owner, rr, streak;
    logic        r [2];
    logic        w [2];
    logic [15:0] a [2];
    logic [15:0] d [2];
    logic        acc_last [2];
    logic        exp_v [2];
    logic        exp_io;
    logic [15:0] exp_rd;

    initial begin
        tbl[0]  = mk(4'b1000, 16'h0010, 16'h0000, 16'h0000, 6'b000000, 16'h0000, 16'h0000);
        tbl[1]  = mk(4'b1000, 16'h0010, 16'h0000, 16'h0000, 6'b100000, 16'h0010, 16'h0000);
        tbl[2]  = mk(4'b0000, 16'h0010, 16'h0000, 16'h0000, 6'b100100, 16'h0010, 16'hBEEF);
        tbl[3]  = mk(4'b0000, 16'h0000, 16'h0000, 16'h0000, 6'b000000, 16'h0000, 16'h0000);
        tbl[4]  = mk(4'b1010, 16'h0100, 16'h0200, 16'h0000, 6'b000000, 16'h0000, 16'h0000);
        tbl[5]  = mk(4'b1010, 16'h0100, 16'h0200, 16'h0000, 6'b100000, 16'h0100, 16'h0000);
        tbl[6]  = mk(4'b1010, 16'h0100, 16'h0200, 16'h0000, 6'b100100, 16'h0100, 16'h0000);
        tbl[7]  = mk(4'b1010, 16'h0100, 16'h0200, 16'h0000, 6'b100100, 16'h0100, 16'h0000);
        tbl[8]  = mk(4'b1010, 16'h0100, 16'h0200, 16'h0000, 6'b100100, 16'h0100, 16'h0000);
        tbl[9]  = mk(4'b1010, 16'h0100, 16'h0200, 16'h0000, 6'b010100, 16'h0200, 16'h0000);
        tbl[10] = mk(4'b1010, 16'h0100, 16'h0200, 16'h0000, 6'b010010, 16'h0200, 16'h0000);
        tbl[11] = mk(4'b1010, 16'h0100, 16'h0200, 16'h0000, 6'b010010, 16'h0200, 16'h0000);
        tbl[12] = mk(4'b1010, 16'h0100, 16'h0200, 16'h0000, 6'b010010, 16'h0200, 16'h0000);
        tbl[13] = mk(4'b1010, 16'h0100, 16'h0200, 16'h0000, 6'b100010, 16'h0100, 16'h0000);
        tbl[14] = mk(4'b1010, 16'h0100, 16'h0200, 16'h0000, 6'b100100, 16'h0100, 16'h0000);
        tbl[15] = mk(4'b1010, 16'h0100, 16'h0200, 16'h0000, 6'b100100, 16'h0100, 16'h0000);
        tbl[16] = mk(4'b1010, 16'h0020, 16'h0200, 16'h0000, 6'b100100, 16'h0020, 16'h0000);
        tbl[17] = mk(4'b1011, 16'h0020, 16'hCFFE, 16'h1234, 6'b010100, 16'hCFFE, 16'hCAFE);
        tbl[18] = mk(4'b1011, 16'h0020, 16'h5000, 16'h5555, 6'b011001, 16'h5000, 16'h0000);
        tbl[19] = mk(4'b1000, 16'h5000, 16'h5000, 16'h0000, 6'b010000, 16'h5000, 16'h0000);
        tbl[20] = mk(4'b1000, 16'h5000, 16'h5000, 16'h0000, 6'b100000, 16'h5000, 16'h0000);
        tbl[21] = mk(4'b1000, 16'hCFFE, 16'h5000, 16'h0000, 6'b100100, 16'hCFFE, 16'h5555);
        tbl[22] = mk(4'b0000, 16'hCFFE, 16'h5000, 16'h0000, 6'b100100, 16'hCFFE, 16'h0000);
        tbl[23] = mk(4'b0000, 16'h0000, 16'h0000, 16'h0000, 6'b000000, 16'h0000, 16'h0000);

        for (int i = 0; i < 65536; i++) ram[i] = 16'h0000;
        ram[16'h0010] = 16'hBEEF;
        ram[16'h0020] = 16'hCAFE;

        reset = 1'b1;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        step();
        step();
        chk("rst_gnt0",     32'(gnt0),     32'd0);
        chk("rst_gnt1",     32'(gnt1),     32'd0);
        chk("rst_rvalid0",  32'(rvalid0),  32'd0);
        chk("rst_rvalid1",  32'(rvalid1),  32'd0);
        chk("rst_io_block", 32'(io_block), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        reset = 1'b0;

        // Directed table: single read, rotation, handover read, I/O write blocking
        for (int i = 0; i < NV; i++) begin
            req0 = tbl[i].r0; we0 = tbl[i].w0; addr0 = tbl[i].a0; wdata0 = 16'h0000;
            req1 = tbl[i].r1; we1 = tbl[i].w1; addr1 = tbl[i].a1; wdata1 = tbl[i].d1;
            #1;
            chk($sformatf("tbl%0d_gnt0", i),     32'(gnt0),     32'(tbl[i].g0));
            chk($sformatf("tbl%0d_gnt1", i),     32'(gnt1),     32'(tbl[i].g1));
            chk($sformatf("tbl%0d_mem_we", i),   32'(mem_we),   32'(tbl[i].we));
            chk($sformatf("tbl%0d_mem_addr", i), 32'(mem_addr), 32'(tbl[i].maddr));
            chk($sformatf("tbl%0d_rvalid0", i),  32'(rvalid0),  32'(tbl[i].v0));
            chk($sformatf("tbl%0d_rvalid1", i),  32'(rvalid1),  32'(tbl[i].v1));
            chk($sformatf("tbl%0d_io_block", i), 32'(io_block), 32'(tbl[i].io));
            if (tbl[i].we) chk($sformatf("tbl%0d_mem_wdata", i), 32'(mem_wdata), 32'(tbl[i].d1));
            if (tbl[i].v0 || tbl[i].v1) chk($sformatf("tbl%0d_rdata", i), 32'(rdata), 32'(tbl[i].rd));
            step();
        end

        // Reset while requester 1 owns the port with a read in flight
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0040;
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0050;
        step();
        chk("t5_own0", 32'(gnt0), 32'd1);
        req0 = 1'b0;
        step();
        chk("t5_own1", 32'(gnt1), 32'd1);
        reset = 1'b1;
        step();
        chk("t5_rst_gnt0",    32'(gnt0),    32'd0);
        chk("t5_rst_gnt1",    32'(gnt1),    32'd0);
        chk("t5_rst_rvalid1", 32'(rvalid1), 32'd0);
        reset = 1'b0;
        req0 = 1'b1;
        step();
        chk("t5_rr_gnt0", 32'(gnt0), 32'd1);
        chk("t5_rr_gnt1", 32'(gnt1), 32'd0);

        // Owner drops after two accesses, then a fresh owner starts a full hold window
        req1 = 1'b0;
        step();
        chk("t6_second", 32'(gnt0), 32'd1);
        step();
        req0 = 1'b0;
        chk("t6_third_gnt0", 32'(gnt0), 32'd1);
        step();
        chk("t6_idle_gnt0", 32'(gnt0), 32'd0);
        chk("t6_idle_gnt1", 32'(gnt1), 32'd0);
        req1 = 1'b1;
        step();
        req0 = 1'b1;
        for (int k = 0; k < int'(MAX_HOLD); k++) begin
            chk($sformatf("t6_hold%0d_gnt1", k), 32'(gnt1), 32'd1);
            step();
        end
        chk("t6_handover_gnt0", 32'(gnt0), 32'd1);
        chk("t6_handover_gnt1", 32'(gnt1), 32'd0);

        // Random traffic against the ownership model
        req0 = 1'b0; req1 = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 65536; i++) ref_ram[i] = ram[i];
        owner = -1; rr = 0; streak = 0;
        exp_io = 1'b0; exp_rd = '0;
        for (int i = 0; i < 2; i++) begin
            r[i] = 1'b0; w[i] = 1'b0; a[i] = '0; d[i] = '0;
            acc_last[i] = 1'b0; exp_v[i] = 1'b0;
        end

        for (int n = 0; n < NRAND; n++) begin
            logic        acc, exp_we;
            logic [15:0] exp_addr;
            int          o, x;
            for (int i = 0; i < 2; i++) begin
                if (!r[i] || acc_last[i]) begin
                    r[i] = ($urandom_range(0, 99) < 55);
                    w[i] = ($urandom_range(0, 2) == 0);
                    if ($urandom_range(0, 3) == 0)
                        a[i] = 16'(int'(IO_BASE) - 2 + int'($urandom_range(0, 3)));
                    else
                        a[i] = 16'($urandom_range(0, 63));
                    d[i] = 16'($urandom);
                end
            end
            req0 = r[0]; we0 = w[0]; addr0 = a[0]; wdata0 = d[0];
            req1 = r[1]; we1 = w[1]; addr1 = a[1]; wdata1 = d[1];
            #1;

            o        = owner;
            acc      = (o >= 0) && r[o];
            exp_addr = (o >= 0) ? a[o] : 16'h0000;
            exp_we   = acc && w[o] && (a[o] < IO_BASE);

            chk("rnd_gnt0",     32'(gnt0),     32'(o == 0));
            chk("rnd_gnt1",     32'(gnt1),     32'(o == 1));
            chk("rnd_mem_addr", 32'(mem_addr), 32'(exp_addr));
            chk("rnd_mem_we",   32'(mem_we),   32'(exp_we));
            if (exp_we) chk("rnd_mem_wdata", 32'(mem_wdata), 32'(d[o]));
            chk("rnd_rvalid0",  32'(rvalid0),  32'(exp_v[0]));
            chk("rnd_rvalid1",  32'(rvalid1),  32'(exp_v[1]));
            chk("rnd_io_block", 32'(io_block), 32'(exp_io));
            if (exp_v[0] || exp_v[1]) chk("rnd_rdata", 32'(rdata), 32'(exp_rd));

            // Effects of this cycle's access
            for (int i = 0; i < 2; i++) begin
                acc_last[i] = acc && (o == i);
                exp_v[i]    = acc && (o == i) && !w[i];
            end
            exp_io = acc && w[o] && (a[o] >= IO_BASE);
            if (acc && !w[o]) exp_rd = ref_ram[a[o]];
            if (exp_we) ref_ram[a[o]] = d[o];

            // Ownership for the next cycle
            if (o < 0) begin
                if (r[0] && r[1]) owner = rr;
                else if (r[0])    owner = 0;
                else if (r[1])    owner = 1;
            end else begin
                x = 1 - o;
                if (r[x] && (!r[o] || streak + 1 == int'(MAX_HOLD))) begin
                    owner = x; rr = x; streak = 0;
                end else if (r[o]) begin
                    streak = r[x] ? streak + 1 : 0;
                end else begin
                    owner = -1; streak = 0;
                end
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/exram_portb_arbiter.md
Name: exram_portb_arbiter

Overview:
- Shares EXRAM port B between two requesters: req 0 is the display scanner, req 1 is the debug/loader.
- Round-robin ownership with a bounded hold count, so neither requester can starve the other.
- Drives the port B address, data and write-enable directly, and returns port B read data with a one-cycle-delayed valid strobe.
- Blocks writes into the memory-mapped I/O window at or above IO_BASE.

Parameters:
WIDTH, 16, data width of port B and the requesters.
ADDR_W, 16, address width.
IO_BASE, 16'hCFFD, first I/O address. Writes at or above it never reach the RAM.
MAX_HOLD, 4, max consecutive accepted accesses by one owner while the other requester is waiting (>=1).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req0  in  1  requester 0 access request; held with addr0/we0/wdata0 stable until accepted
we0  in  1  requester 0 write (1) / read (0)
addr0  in  ADDR_W  requester 0 address
wdata0  in  WIDTH  requester 0 write data
gnt0  out  1  requester 0 owns port B; access accepted in any cycle with req0&gnt0
rvalid0  out  1  rdata holds requester 0 read result
req1, we1, addr1, wdata1  in  1/1/ADDR_W/WIDTH  requester 1 equivalents
gnt1, rvalid1  out  1/1  requester 1 equivalents
rdata  out  WIDTH  read data, shared; qualified by rvalid0/rvalid1
mem_addr  out  ADDR_W  EXRAM address_b
mem_wdata  out  WIDTH  EXRAM data_b
mem_we  out  1  EXRAM wren_b
mem_q  in  WIDTH  EXRAM q_b (synchronous read, valid one cycle after address)
io_block  out  1  1-cycle pulse: an accepted write targeted addr >= IO_BASE and was suppressed

Behaviour:
- Reset values: state=IDLE, rr_ptr=0 (requester 0 favoured), hold_cnt=0, gnt0=gnt1=0, rvalid0=rvalid1=0, io_block=0. Reset mid-transfer drops ownership and any pending rvalid next edge.
- States: IDLE, OWN0, OWN1 (registered). gnt0=(state==OWN0), gnt1=(state==OWN1); never both.
- IDLE:
  - req0 only -> OWN0.
  - req1 only -> OWN1.
  - both -> OWN0 if rr_ptr==0, else OWN1.
  - neither -> stay.
  - No access is performed in IDLE, so first-access latency is one cycle after req rises.
- OWNx:
  - If req_x is high, the access is accepted this cycle and hold_cnt increments.
  - To other: when req_x is low and req_other is high, or when req_other is high and hold_cnt reaches MAX_HOLD-1 on an accepted access. On switch, hold_cnt<=0 and rr_ptr<=other.
  - To IDLE: when neither is requesting.
  - Stay: when req_x is high and req_other is low. hold_cnt saturates and only counts while other waits; it clears when other is idle.
- Handover costs zero idle cycles: the cycle after the last accepted owner access, the other requester is granted.
- Mux:
  - mem_addr/mem_wdata follow the current owner's inputs.
  - In IDLE they hold 0.
  - mem_we = owner_req & owner_we & (owner_addr < IO_BASE), unsigned compare.
- io_block: registered. Asserted for one cycle after an accepted write with owner_addr >= IO_BASE.
- Reads:
  - An accepted read in cycle t gives rvalid_owner=1 in t+1, with rdata=mem_q combinationally in t+1.
  - Back-to-back reads produce consecutive rvalids.
  - A read accepted in the last owned cycle still returns to the original requester after handover.
  - Writes never produce rvalid.
- Reads at addresses >= IO_BASE are forwarded unchanged. I/O substitution is done by the top level, not here.

Test Plan:
1. Reset high 2 cycles, then req0=1, we0=0, addr0=16'h0010, RAM[0x10]=16'hBEEF -> gnt0=1 in cycle 1. mem_addr=0x0010 in cycle 1; rvalid0=1 and rdata=16'hBEEF in cycle 2. gnt1, rvalid1 stay 0.
2. req0 and req1 held high continuously from IDLE, MAX_HOLD=4 -> grant order 0,0,0,0,1,1,1,1,0… with no idle cycles and never both gnt high.
3. req1 write addr1=16'hCFFE, wdata1=16'h1234 -> mem_we=0 in the accepted cycle, io_block=1 next cycle. A write to 16'h5000 gives mem_we=1, io_block=0.
4. OWN0 read to 0x0020 on its last cycle, req1 waiting -> next cycle gnt1=1 and rvalid0=1 with RAM[0x20]; rvalid1=0.
5. Assert reset during OWN1 with a read accepted in the same cycle -> next cycle state IDLE, gnt1=0, rvalid1=0. After release, simultaneous requests grant requester 0 first.
6. req0 drops after 2 accesses while req1 is idle -> IDLE. req1 then rises -> gnt1 one cycle later, hold_cnt starts from 0.
